// File: rtl/mochila_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mochila_ram_arbiter
// Purpose  : Round-robin OBI arbiter sharing one RAM bank among NREQ requesters
// Revision : 1.0 - initial release
// ============================================================================

package mochila_obi_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module mochila_ram_arbiter
  import mochila_obi_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_OUTST = 2,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  obi_req_t  [NREQ-1:0]           master_req_i,
  output obi_resp_t [NREQ-1:0]           master_resp_o,
  output obi_req_t                       slave_req_o,
  input  obi_resp_t                      slave_resp_i,
  output logic [$clog2(MAX_OUTST+1)-1:0] outstanding_o,
  output logic                           err_o
);

  localparam int c_cnt_w = $clog2(MAX_OUTST + 1);
  localparam int c_ptr_w = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [IDW-1:0]     r_rr;
  logic               r_lock;
  logic [IDW-1:0]     r_lock_id;
  logic [IDW-1:0]     r_fifo [MAX_OUTST];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_err;

  logic               w_win_valid;
  logic [IDW-1:0]     w_win_id;
  logic [IDW:0]       w_idx;
  logic               w_full;
  logic               w_slv_req;
  logic               w_push;
  logic               w_stall;
  logic               w_pop;
  logic               w_spurious;
  logic [IDW-1:0]     w_head;
  logic [IDW-1:0]     w_rr_next;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    if (p == c_ptr_w'(MAX_OUTST - 1)) return '0;
    else                              return p + 1'b1;
  endfunction

  // Scan offsets from highest to lowest so the requester closest to r_rr wins.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = r_rr;
    w_idx       = '0;
    if (r_lock) begin
      w_win_valid = 1'b1;
      w_win_id    = r_lock_id;
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        w_idx = {1'b0, r_rr} + (IDW+1)'(k);
        if (w_idx >= (IDW+1)'(NREQ)) w_idx = w_idx - (IDW+1)'(NREQ);
        if (master_req_i[w_idx[IDW-1:0]].req) begin
          w_win_valid = 1'b1;
          w_win_id    = w_idx[IDW-1:0];
        end
      end
    end
  end

  assign w_full     = (r_count == c_cnt_w'(MAX_OUTST));
  assign w_slv_req  = !rst_i && w_win_valid && !w_full;
  assign w_push     = w_slv_req && slave_resp_i.gnt;
  assign w_stall    = w_slv_req && !slave_resp_i.gnt;
  assign w_pop      = !rst_i && slave_resp_i.rvalid && (r_count != '0);
  assign w_spurious = !rst_i && slave_resp_i.rvalid && (r_count == '0);
  assign w_head     = r_fifo[r_rptr];
  assign w_rr_next  = (w_win_id == IDW'(NREQ - 1)) ? '0 : w_win_id + 1'b1;

  always_comb begin
    slave_req_o = '0;
    if (w_slv_req) begin
      slave_req_o     = master_req_i[w_win_id];
      slave_req_o.req = 1'b1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_resp
    assign master_resp_o[g] = {w_push && (w_win_id == IDW'(g)),
                               w_pop && (w_head == IDW'(g)),
                               slave_resp_i.rdata};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr      <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
        r_rr   <= w_rr_next;
        r_lock <= 1'b0;
      end else if (w_stall) begin
        // Hold the stalled address phase until the slave accepts it.
        r_lock    <= 1'b1;
        r_lock_id <= w_win_id;
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_spurious) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= w_win_id;
  end

  assign outstanding_o = r_count;
  assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mochila_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mochila_ram_arbiter
// Purpose  : Directed self-checking bench for mochila_ram_arbiter (4 ports)
// Revision : 1.0 - initial release
// ============================================================================
module tb_mochila_ram_arbiter;
  import mochila_obi_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  obi_req_t  [3:0]     m_req;
  obi_resp_t [3:0]     m_resp;
  obi_req_t            s_req;
  obi_resp_t           s_resp;
  logic [1:0]          outst;
  logic                err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mochila_ram_arbiter #(.NREQ(4), .MAX_OUTST(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .master_req_i (m_req),
    .master_resp_o(m_resp),
    .slave_req_o  (s_req),
    .slave_resp_i (s_resp),
    .outstanding_o(outst),
    .err_o        (err)
  );

  function automatic logic [3:0] gnt_vec();
    for (int i = 0; i < 4; i++) gnt_vec[i] = m_resp[i].gnt;
  endfunction

  function automatic logic [3:0] rv_vec();
    for (int i = 0; i < 4; i++) rv_vec[i] = m_resp[i].rvalid;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    m_req  = '0;
    s_resp = '0;
  endtask

  task automatic set_req(input int p, input logic [31:0] a);
    m_req[p].req   = 1'b1;
    m_req[p].addr  = a;
    m_req[p].we    = 1'b0;
    m_req[p].be    = 4'hF;
    m_req[p].wdata = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 32'h40 + i);
    s_resp = '{gnt: 1'b1, rvalid: 1'b1, rdata: 32'h1234};
    cyc(); #1;
    checks++; if (outst !== 2'd0) begin failures++; $display("FAIL reset_outst got=%0d exp=0", outst); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (s_req !== '0) begin failures++; $display("FAIL reset_sreq got=%h exp=0", s_req); end
    checks++; if (gnt_vec() !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt_vec()); end
    checks++; if (rv_vec() !== 4'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0000", rv_vec()); end
    idle();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_single();
    cyc();
    set_req(2, 32'h100);
    s_resp.gnt = 1'b1;
    #1;
    checks++; if (s_req.req !== 1'b1 || s_req.addr !== 32'h100) begin failures++; $display("FAIL single_sreq got req=%b addr=%h exp req=1 addr=00000100", s_req.req, s_req.addr); end
    checks++; if (gnt_vec() !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt_vec()); end
    checks++; if (outst !== 2'd0) begin failures++; $display("FAIL single_outst0 got=%0d exp=0", outst); end
    cyc();
    idle();
    s_resp = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'hDEADBEEF};
    #1;
    checks++; if (outst !== 2'd1) begin failures++; $display("FAIL single_outst1 got=%0d exp=1", outst); end
    checks++; if (rv_vec() !== 4'b0100) begin failures++; $display("FAIL single_rvalid got=%b exp=0100", rv_vec()); end
    checks++; if (m_resp[2].rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rdata got=%h exp=deadbeef", m_resp[2].rdata); end
    checks++; if (gnt_vec() !== 4'b0) begin failures++; $display("FAIL single_nognt got=%b exp=0000", gnt_vec()); end
    cyc();
    idle();
    #1;
    checks++; if (outst !== 2'd0) begin failures++; $display("FAIL single_outst2 got=%0d exp=0", outst); end
    checks++; if (rv_vec() !== 4'b0) begin failures++; $display("FAIL single_idle_rv got=%b exp=0000", rv_vec()); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    logic [3:0] exp_r;
    do_reset();
    cyc();
    for (int i = 0; i < 4; i++) set_req(i, 32'h1000 + i * 4);
    s_resp.gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_resp.rvalid = (k > 0);
      s_resp.rdata  = 32'(k);
      #1;
      exp_g = 4'b0001 << (k % 4);
      checks++; if (gnt_vec() !== exp_g) begin failures++; $display("FAIL fair_gnt k=%0d got=%b exp=%b", k, gnt_vec(), exp_g); end
      checks++; if (s_req.addr !== 32'h1000 + (k % 4) * 4) begin failures++; $display("FAIL fair_addr k=%0d got=%h", k, s_req.addr); end
      if (k > 0) begin
        exp_r = 4'b0001 << ((k - 1) % 4);
        checks++; if (rv_vec() !== exp_r) begin failures++; $display("FAIL fair_rv k=%0d got=%b exp=%b", k, rv_vec(), exp_r); end
        checks++; if (outst !== 2'd1) begin failures++; $display("FAIL fair_outst k=%0d got=%0d exp=1", k, outst); end
      end
      cyc();
    end
    m_req = '0;
    s_resp.gnt = 1'b0;
    #1;
    checks++; if (rv_vec() !== 4'b1000) begin failures++; $display("FAIL fair_last_rv got=%b exp=1000", rv_vec()); end
    cyc();
    idle();
    #1;
    checks++; if (outst !== 2'd0) begin failures++; $display("FAIL fair_drain got=%0d exp=0", outst); end
  endtask

  task automatic test_stall();
    do_reset();
    cyc();
    set_req(1, 32'h111);
    set_req(3, 32'h333);
    for (int s = 0; s < 3; s++) begin
      if (s == 1) set_req(0, 32'h0AA);
      #1;
      checks++; if (s_req.req !== 1'b1 || s_req.addr !== 32'h111) begin failures++; $display("FAIL stall_addr s=%0d got req=%b addr=%h exp 1/111", s, s_req.req, s_req.addr); end
      checks++; if (gnt_vec() !== 4'b0) begin failures++; $display("FAIL stall_gnt s=%0d got=%b exp=0000", s, gnt_vec()); end
      cyc();
    end
    s_resp.gnt = 1'b1;
    #1;
    checks++; if (gnt_vec() !== 4'b0010 || s_req.addr !== 32'h111) begin failures++; $display("FAIL stall_release got gnt=%b addr=%h exp 0010/111", gnt_vec(), s_req.addr); end
    cyc();
    m_req[1] = '0;
    #1;
    checks++; if (gnt_vec() !== 4'b1000 || s_req.addr !== 32'h333) begin failures++; $display("FAIL stall_next got gnt=%b addr=%h exp 1000/333", gnt_vec(), s_req.addr); end
    checks++; if (outst !== 2'd1) begin failures++; $display("FAIL stall_outst1 got=%0d exp=1", outst); end
    cyc();
    idle();
    s_resp = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'h11};
    #1;
    checks++; if (outst !== 2'd2 || rv_vec() !== 4'b0010) begin failures++; $display("FAIL stall_rv1 got outst=%0d rv=%b exp 2/0010", outst, rv_vec()); end
    cyc();
    s_resp.rdata = 32'h33;
    #1;
    checks++; if (rv_vec() !== 4'b1000 || m_resp[3].rdata !== 32'h33) begin failures++; $display("FAIL stall_rv3 got rv=%b rdata=%h exp 1000/33", rv_vec(), m_resp[3].rdata); end
    cyc();
    idle();
    #1;
    checks++; if (outst !== 2'd0) begin failures++; $display("FAIL stall_drain got=%0d exp=0", outst); end
  endtask

  task automatic test_backpressure();
    do_reset();
    cyc();
    set_req(0, 32'hA0);
    set_req(1, 32'hA1);
    s_resp.gnt = 1'b1;
    #1;
    checks++; if (gnt_vec() !== 4'b0001 || outst !== 2'd0) begin failures++; $display("FAIL bp_c0 got gnt=%b outst=%0d exp 0001/0", gnt_vec(), outst); end
    cyc(); #1;
    checks++; if (gnt_vec() !== 4'b0010 || outst !== 2'd1) begin failures++; $display("FAIL bp_c1 got gnt=%b outst=%0d exp 0010/1", gnt_vec(), outst); end
    for (int c = 2; c < 4; c++) begin
      cyc(); #1;
      checks++; if (s_req.req !== 1'b0 || gnt_vec() !== 4'b0 || outst !== 2'd2) begin failures++; $display("FAIL bp_full c=%0d got req=%b gnt=%b outst=%0d exp 0/0000/2", c, s_req.req, gnt_vec(), outst); end
    end
    cyc();
    s_resp.rvalid = 1'b1;
    s_resp.rdata  = 32'hB0;
    #1;
    checks++; if (s_req.req !== 1'b0 || rv_vec() !== 4'b0001 || m_resp[0].rdata !== 32'hB0) begin failures++; $display("FAIL bp_c4 got req=%b rv=%b rdata=%h exp 0/0001/b0", s_req.req, rv_vec(), m_resp[0].rdata); end
    cyc();
    s_resp.rdata = 32'hB1;
    #1;
    checks++; if (rv_vec() !== 4'b0010 || gnt_vec() !== 4'b0001 || outst !== 2'd1) begin failures++; $display("FAIL bp_c5 got rv=%b gnt=%b outst=%0d exp 0010/0001/1", rv_vec(), gnt_vec(), outst); end
    cyc();
    m_req = '0;
    s_resp.gnt   = 1'b0;
    s_resp.rdata = 32'hB2;
    #1;
    checks++; if (rv_vec() !== 4'b0001 || outst !== 2'd1) begin failures++; $display("FAIL bp_c6 got rv=%b outst=%0d exp 0001/1", rv_vec(), outst); end
    cyc();
    idle();
    #1;
    checks++; if (outst !== 2'd0) begin failures++; $display("FAIL bp_drain got=%0d exp=0", outst); end
  endtask

  task automatic test_spurious();
    do_reset();
    cyc();
    s_resp = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'hBAD};
    #1;
    checks++; if (rv_vec() !== 4'b0 || err !== 1'b0) begin failures++; $display("FAIL spur_now got rv=%b err=%b exp 0000/0", rv_vec(), err); end
    cyc();
    idle();
    #1;
    checks++; if (err !== 1'b1 || outst !== 2'd0) begin failures++; $display("FAIL spur_err got err=%b outst=%0d exp 1/0", err, outst); end
    cyc();
    cyc();
    #1;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL spur_sticky got=%b exp=1", err); end
  endtask

  task automatic test_reset_midflight();
    cyc();
    set_req(0, 32'hC0);
    set_req(1, 32'hC1);
    s_resp.gnt = 1'b1;
    cyc();
    cyc();
    #1;
    checks++; if (outst !== 2'd2) begin failures++; $display("FAIL mid_outst2 got=%0d exp=2", outst); end
    rst = 1'b1;
    #1;
    checks++; if (gnt_vec() !== 4'b0 || s_req.req !== 1'b0) begin failures++; $display("FAIL mid_rst_out got gnt=%b req=%b exp 0000/0", gnt_vec(), s_req.req); end
    cyc();
    #1;
    checks++; if (outst !== 2'd0 || err !== 1'b0) begin failures++; $display("FAIL mid_cleared got outst=%0d err=%b exp 0/0", outst, err); end
    rst = 1'b0;
    idle();
    set_req(1, 32'hD1);
    set_req(3, 32'hD3);
    #1;
    checks++; if (s_req.addr !== 32'hD1) begin failures++; $display("FAIL mid_rr got addr=%h exp=000000d1", s_req.addr); end
    cyc();
    do_reset();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_backpressure();
    test_spurious();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
